// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - shared size encodings, FSM states and alignment helpers for the LSU
package lsu_pkg;

  localparam logic [3:0] SIZE_B = 4'b0001;
  localparam logic [3:0] SIZE_H = 4'b0011;
  localparam logic [3:0] SIZE_W = 4'b1111;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT_R,
    DONE
  } lsu_state_e;

  function automatic logic is_misaligned(input logic [3:0] size, input logic [1:0] off);
    return ((size == SIZE_H) && off[0]) || ((size == SIZE_W) && (off != 2'b00));
  endfunction

  function automatic logic is_legal_size(input logic [3:0] size);
    return (size == SIZE_B) || (size == SIZE_H) || (size == SIZE_W);
  endfunction

endpackage

// File: rtl/lsu_load_align.sv
// rtl/lsu_load_align.sv - shifts a loaded word down to its byte lane and sign/zero-extends it
module lsu_load_align
  import lsu_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  offset,
  input  logic [3:0]  size,
  input  logic        is_unsigned,
  output logic [31:0] result
);

  logic [31:0] shifted;

  always_comb begin
    shifted = rdata >> {offset, 3'b000};
    result  = shifted;
    case (size)
      SIZE_B:  result = {{24{~is_unsigned & shifted[7]}}, shifted[7:0]};
      SIZE_H:  result = {{16{~is_unsigned & shifted[15]}}, shifted[15:0]};
      default: result = shifted;
    endcase
  end

endmodule

// File: rtl/lsu_dmem_ctrl.sv
// rtl/lsu_dmem_ctrl.sv - load/store stage driving a req/gnt/rvalid data-memory port
module lsu_dmem_ctrl
  import lsu_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_valid,
  input  logic              i_mem_read,
  input  logic              i_mem_write,
  input  logic [3:0]        i_d_size,
  input  logic              i_d_unsigned,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [DATA_W-1:0] i_wdata,
  output logic              o_dmem_req,
  output logic              o_dmem_we,
  output logic [3:0]        o_dmem_be,
  output logic [ADDR_W-1:0] o_dmem_addr,
  output logic [DATA_W-1:0] o_dmem_wdata,
  input  logic              i_dmem_gnt,
  input  logic              i_dmem_rvalid,
  input  logic [DATA_W-1:0] i_dmem_rdata,
  output logic              o_stall,
  output logic [DATA_W-1:0] o_rdata,
  output logic              o_done,
  output logic              o_fault
);

  lsu_state_e        state;
  logic [1:0]        lat_off;
  logic [3:0]        lat_size;
  logic              lat_uns;
  logic [1:0]        off;
  logic              access;
  logic              bad;
  logic              go;
  logic [DATA_W-1:0] wdata_rep;
  logic [DATA_W-1:0] load_result;

  assign off     = i_addr[1:0];
  assign access  = (state == IDLE) && i_valid && (i_mem_read || i_mem_write);
  assign bad     = is_misaligned(i_d_size, off) || !is_legal_size(i_d_size);
  assign go      = access && !bad;
  assign o_stall = go || (state == REQ) || (state == WAIT_R);

  always_comb begin
    case (i_d_size)
      SIZE_B:  wdata_rep = {4{i_wdata[7:0]}};
      SIZE_H:  wdata_rep = {2{i_wdata[15:0]}};
      default: wdata_rep = i_wdata;
    endcase
  end

  lsu_load_align u_align (
    .rdata       (i_dmem_rdata),
    .offset      (lat_off),
    .size        (lat_size),
    .is_unsigned (lat_uns),
    .result      (load_result)
  );

  // Write wins when decode raises both strobes, so o_dmem_we alone steers the REQ exit.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state        <= IDLE;
      o_dmem_req   <= 1'b0;
      o_dmem_we    <= 1'b0;
      o_dmem_be    <= 4'b0000;
      o_dmem_addr  <= '0;
      o_dmem_wdata <= '0;
      o_rdata      <= '0;
      o_done       <= 1'b0;
      o_fault      <= 1'b0;
      lat_off      <= 2'b00;
      lat_size     <= 4'b0000;
      lat_uns      <= 1'b0;
    end else begin
      o_done  <= 1'b0;
      o_fault <= access && bad;
      case (state)
        IDLE: begin
          if (go) begin
            state        <= REQ;
            o_dmem_req   <= 1'b1;
            o_dmem_we    <= i_mem_write;
            o_dmem_be    <= i_d_size << off;
            o_dmem_addr  <= {i_addr[ADDR_W-1:2], 2'b00};
            o_dmem_wdata <= wdata_rep;
            lat_off      <= off;
            lat_size     <= i_d_size;
            lat_uns      <= i_d_unsigned;
          end
        end
        REQ: begin
          if (i_dmem_gnt) begin
            o_dmem_req <= 1'b0;
            if (o_dmem_we) begin
              state  <= DONE;
              o_done <= 1'b1;
            end else if (i_dmem_rvalid) begin
              o_rdata <= load_result;
              state   <= DONE;
              o_done  <= 1'b1;
            end else begin
              state <= WAIT_R;
            end
          end
        end
        WAIT_R: begin
          if (i_dmem_rvalid) begin
            o_rdata <= load_result;
            state   <= DONE;
            o_done  <= 1'b1;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_dmem_ctrl.sv
// tb/tb_lsu_dmem_ctrl.sv - self-checking bench for lsu_dmem_ctrl with a memory-side reference model
module tb_lsu_dmem_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        valid, mem_read, mem_write, d_unsigned;
  logic [3:0]  d_size;
  logic [31:0] addr, wdata;
  logic        dmem_req, dmem_we;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_addr, dmem_wdata;
  logic        dmem_gnt, dmem_rvalid;
  logic [31:0] dmem_rdata;
  logic        stall, done, fault;
  logic [31:0] rdata;

  int          passed = 0;
  int          total = 0;
  logic [31:0] hold = 32'h0;

  always #5 clk = ~clk;

  lsu_dmem_ctrl #(.ADDR_W(32), .DATA_W(32)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_valid(valid), .i_mem_read(mem_read),
    .i_mem_write(mem_write), .i_d_size(d_size), .i_d_unsigned(d_unsigned),
    .i_addr(addr), .i_wdata(wdata), .o_dmem_req(dmem_req), .o_dmem_we(dmem_we),
    .o_dmem_be(dmem_be), .o_dmem_addr(dmem_addr), .o_dmem_wdata(dmem_wdata),
    .i_dmem_gnt(dmem_gnt), .i_dmem_rvalid(dmem_rvalid), .i_dmem_rdata(dmem_rdata),
    .o_stall(stall), .o_rdata(rdata), .o_done(done), .o_fault(fault)
  );

  task automatic do_access(input logic rd, input logic wr, input logic [3:0] size,
                           input logic uns, input logic [31:0] a, input logic [31:0] wd,
                           input logic [31:0] mem_word, input int gd, input int rdly,
                           input string tag);
    int          n, off;
    longint      v;
    logic [3:0]  exp_be;
    logic [31:0] exp_wd, exp_ld;
    n   = (size == 4'b0001) ? 1 : (size == 4'b0011) ? 2 : 4;
    off = a % 4;
    exp_be = 4'b0000;
    for (int i = 0; i < 4; i++) begin
      if (i >= off && i < off + n) exp_be[i] = 1'b1;
      exp_wd[8*i +: 8] = wd[8*(i % n) +: 8];
    end
    v = longint'(mem_word) >> (8 * off);
    if (n < 4) begin
      v = v % (64'd1 << (8 * n));
      if (!uns && v >= (64'd1 << (8 * n - 1))) v = v - (64'd1 << (8 * n));
    end
    exp_ld = v[31:0];

    @(negedge clk);
    total++; if (done !== 1'b0) $display("FAIL %s idle_done got=%0b exp=0", tag, done); else passed++;
    total++; if (rdata !== hold) $display("FAIL %s rdata_hold got=%h exp=%h", tag, rdata, hold); else passed++;
    valid = 1'b1; mem_read = rd; mem_write = wr; d_size = size; d_unsigned = uns;
    addr = a; wdata = wd;
    #1;
    total++; if (stall !== 1'b1) $display("FAIL %s start_stall got=%0b exp=1", tag, stall); else passed++;
    @(negedge clk);
    valid = 1'b0; mem_read = 1'b0; mem_write = 1'b0; addr = $urandom; wdata = $urandom;
    d_size = 4'($urandom);
    for (int k = 0; k < gd; k++) begin
      total++;
      if (dmem_req !== 1'b1 || stall !== 1'b1)
        $display("FAIL %s req_wait got req=%0b stall=%0b exp=1,1", tag, dmem_req, stall);
      else passed++;
      @(negedge clk);
    end
    total++; if (dmem_req !== 1'b1) $display("FAIL %s req got=%0b exp=1", tag, dmem_req); else passed++;
    total++; if (dmem_we !== wr) $display("FAIL %s we got=%0b exp=%0b", tag, dmem_we, wr); else passed++;
    total++; if (dmem_be !== exp_be) $display("FAIL %s be got=%b exp=%b", tag, dmem_be, exp_be); else passed++;
    total++;
    if (dmem_addr !== {a[31:2], 2'b00}) $display("FAIL %s addr got=%h exp=%h", tag, dmem_addr, {a[31:2], 2'b00});
    else passed++;
    if (wr) begin
      total++;
      if (dmem_wdata !== exp_wd) $display("FAIL %s wdata got=%h exp=%h", tag, dmem_wdata, exp_wd);
      else passed++;
    end
    dmem_gnt = 1'b1;
    if (!wr && rdly == 0) begin dmem_rvalid = 1'b1; dmem_rdata = mem_word; end
    @(negedge clk);
    dmem_gnt = 1'b0; dmem_rvalid = 1'b0;
    if (!wr && rdly > 0) begin
      for (int k = 0; k < rdly - 1; k++) begin
        dmem_rdata = $urandom;
        total++;
        if (dmem_req !== 1'b0 || stall !== 1'b1)
          $display("FAIL %s wait_r got req=%0b stall=%0b exp=0,1", tag, dmem_req, stall);
        else passed++;
        @(negedge clk);
      end
      dmem_rvalid = 1'b1; dmem_rdata = mem_word;
      @(negedge clk);
      dmem_rvalid = 1'b0;
    end
    total++; if (done !== 1'b1) $display("FAIL %s done got=%0b exp=1", tag, done); else passed++;
    total++;
    if (stall !== 1'b0 || dmem_req !== 1'b0)
      $display("FAIL %s done_quiet got stall=%0b req=%0b exp=0,0", tag, stall, dmem_req);
    else passed++;
    if (!wr) begin
      hold = exp_ld;
      total++; if (rdata !== exp_ld) $display("FAIL %s load got=%h exp=%h", tag, rdata, exp_ld); else passed++;
    end
  endtask

  task automatic do_fault(input logic [3:0] size, input logic [31:0] a, input logic wr, input string tag);
    @(negedge clk);
    valid = 1'b1; mem_read = ~wr; mem_write = wr; d_size = size; d_unsigned = 1'b0; addr = a;
    #1;
    total++; if (stall !== 1'b0) $display("FAIL %s fault_stall got=%0b exp=0", tag, stall); else passed++;
    @(negedge clk);
    valid = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
    total++; if (fault !== 1'b1) $display("FAIL %s fault got=%0b exp=1", tag, fault); else passed++;
    total++; if (dmem_req !== 1'b0) $display("FAIL %s fault_req got=%0b exp=0", tag, dmem_req); else passed++;
    @(negedge clk);
    total++; if (fault !== 1'b0) $display("FAIL %s fault_pulse got=%0b exp=0", tag, fault); else passed++;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; valid = 1'b0; mem_read = 1'b0; mem_write = 1'b0; d_size = 4'b0;
    d_unsigned = 1'b0; addr = '0; wdata = '0; dmem_gnt = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = '0;
    repeat (2) @(negedge clk);
    total++;
    if ({dmem_req, dmem_we, dmem_be, dmem_addr, dmem_wdata, stall, rdata, done, fault} !== '0)
      $display("FAIL reset_outputs got req=%0b be=%b addr=%h rdata=%h done=%0b fault=%0b exp=all 0",
               dmem_req, dmem_be, dmem_addr, rdata, done, fault);
    else passed++;
    rst_n = 1'b1;
  endtask

  task automatic test_stores();
    do_access(1'b0, 1'b1, 4'b1111, 1'b0, 32'h1004, 32'hDEADBEEF, 32'h0, 0, 0, "word_store");
    do_access(1'b0, 1'b1, 4'b0001, 1'b0, 32'h2003, 32'h000000A5, 32'h0, 0, 0, "byte_store");
    do_access(1'b1, 1'b1, 4'b0011, 1'b0, 32'h2006, 32'h1234CAFE, 32'h0, 1, 0, "both_half_store");
  endtask

  task automatic test_loads();
    do_access(1'b1, 1'b0, 4'b0001, 1'b0, 32'h10, 32'h0, 32'h80FF7F01, 0, 0, "lb_0x10");
    do_access(1'b1, 1'b0, 4'b0001, 1'b0, 32'h12, 32'h0, 32'h80FF7F01, 0, 0, "lb_0x12");
    do_access(1'b1, 1'b0, 4'b0001, 1'b1, 32'h13, 32'h0, 32'h80FF7F01, 0, 0, "lbu_0x13");
    do_access(1'b1, 1'b0, 4'b0011, 1'b0, 32'h22, 32'h0, 32'h80011234, 3, 2, "lh_latency");
  endtask

  task automatic test_faults();
    do_fault(4'b0011, 32'h31, 1'b0, "half_0x31");
    do_fault(4'b0111, 32'h40, 1'b0, "size_0111");
    do_fault(4'b1111, 32'h32, 1'b1, "word_0x32");
  endtask

  task automatic test_ignored_inputs();
    @(negedge clk);
    dmem_gnt = 1'b1; dmem_rvalid = 1'b1; dmem_rdata = $urandom;
    @(negedge clk);
    dmem_gnt = 1'b0; dmem_rvalid = 1'b0;
    total++;
    if (dmem_req !== 1'b0 || done !== 1'b0 || rdata !== hold)
      $display("FAIL idle_ignore got req=%0b done=%0b rdata=%h exp=0,0,%h", dmem_req, done, rdata, hold);
    else passed++;
  endtask

  task automatic test_random();
    logic [3:0]  sz;
    logic [31:0] a;
    int          r, s;
    for (int it = 0; it < 30; it++) begin
      s  = $urandom_range(0, 2);
      sz = (s == 0) ? 4'b0001 : (s == 1) ? 4'b0011 : 4'b1111;
      a  = $urandom & 32'hFFFF_FFFC;
      if (s == 0) a[1:0] = 2'($urandom_range(0, 3));
      if (s == 1) a[1] = 1'($urandom_range(0, 1));
      r = $urandom_range(0, 3);
      do_access(r == 1 || r == 2 || r == 3, r == 0 || r == 2, sz, 1'($urandom_range(0, 1)), a,
                $urandom, $urandom, $urandom_range(0, 3), $urandom_range(0, 3), $sformatf("rand%0d", it));
      if (it % 10 == 9) do_fault(4'b1111, a | 32'h1, 1'b0, $sformatf("rand_fault%0d", it));
    end
  endtask

  task automatic test_reset_in_wait_r();
    @(negedge clk);
    valid = 1'b1; mem_read = 1'b1; d_size = 4'b0001; d_unsigned = 1'b0; addr = 32'h40;
    @(negedge clk);
    valid = 1'b0; mem_read = 1'b0; dmem_gnt = 1'b1;
    @(negedge clk);
    dmem_gnt = 1'b0;
    total++; if (stall !== 1'b1) $display("FAIL rst_wait_stall got=%0b exp=1", stall); else passed++;
    rst_n = 1'b0;
    #1;
    total++;
    if (dmem_req !== 1'b0 || stall !== 1'b0 || rdata !== 32'h0)
      $display("FAIL rst_async got req=%0b stall=%0b rdata=%h exp=0,0,0", dmem_req, stall, rdata);
    else passed++;
    hold = 32'h0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    dmem_rvalid = 1'b1; dmem_rdata = 32'h7F7F7F7F;
    @(negedge clk);
    dmem_rvalid = 1'b0;
    total++;
    if (done !== 1'b0 || rdata !== 32'h0 || stall !== 1'b0)
      $display("FAIL rst_late_rvalid got done=%0b rdata=%h stall=%0b exp=0,0,0", done, rdata, stall);
    else passed++;
    do_access(1'b1, 1'b0, 4'b1111, 1'b0, 32'h44, 32'h0, 32'hA5A50F0F, 0, 1, "after_reset");
  endtask

  task automatic test_back_to_back();
    do_access(1'b0, 1'b1, 4'b0001, 1'b0, 32'h101, 32'h0000003C, 32'h0, 0, 0, "b2b_sb");
    do_access(1'b1, 1'b0, 4'b0011, 1'b1, 32'h102, 32'h0, 32'hF00DFACE, 0, 0, "b2b_lhu");
    do_access(1'b1, 1'b0, 4'b1111, 1'b0, 32'h104, 32'h0, 32'h13572468, 0, 0, "b2b_lw");
  endtask

  initial begin
    test_reset();
    test_stores();
    test_loads();
    test_faults();
    test_ignored_inputs();
    test_back_to_back();
    test_random();
    test_reset_in_wait_r();
    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/lsu_dmem_ctrl.md
Name: lsu_dmem_ctrl

Overview:
Load/store execution stage that sits directly downstream of the main control decode. It consumes the decoded memory-access controls (read/write strobes, 4-bit byte-size mask, unsigned flag) together with the ALU-computed address and store data. It drives a req/gnt/rvalid data-memory port, forms byte enables, and replicates store data. It aligns and sign- or zero-extends load data and stalls the pipeline until the access completes.

Parameters:
ADDR_W, 32, data-memory address width
DATA_W, 32, data word width (fixed at 32; other values unsupported)

Ports:
i_clk  in  1  core clock
i_rst_n  in  1  reset, asynchronous, active-low
i_valid  in  1  instruction in this stage is valid
i_mem_read  in  1  load request from decode
i_mem_write  in  1  store request from decode
i_d_size  in  4  byte-size mask: 0001 byte, 0011 half, 1111 word
i_d_unsigned  in  1  zero-extend load result
i_addr  in  ADDR_W  effective address
i_wdata  in  32  store source register value
o_dmem_req  out  1  memory request
o_dmem_we  out  1  write enable
o_dmem_be  out  4  byte enables
o_dmem_addr  out  ADDR_W  word-aligned address (low two bits forced to 0)
o_dmem_wdata  out  32  lane-replicated store data
i_dmem_gnt  in  1  request accepted
i_dmem_rvalid  in  1  read data valid
i_dmem_rdata  in  32  read data
o_stall  out  1  hold upstream pipeline
o_rdata  out  32  aligned, extended load result
o_done  out  1  one-cycle pulse when access completes
o_fault  out  1  one-cycle pulse on misaligned or illegal-size access

Behaviour:
- Reset (async, i_rst_n=0): state IDLE. All outputs 0, including the registered o_dmem_* outputs, o_rdata, o_done and o_fault.
- FSM states: IDLE, REQ, WAIT_R, DONE.
- Access start condition: i_valid && (i_mem_read || i_mem_write) in IDLE.
  - If both read and write are set, write wins.
- Fault check in IDLE:
  - Misaligned: half with addr[0]=1, or word with addr[1:0]!=0.
  - Illegal size: i_d_size not one of 0001/0011/1111.
  - On fault: o_fault pulses the next cycle, no request is issued, o_stall stays 0, state stays IDLE.
- Legal start: latch addr, be, we, wdata, size and unsigned flag, then go to REQ. o_stall is asserted combinationally in that same cycle.
- Byte enables: o_dmem_be = i_d_size << addr[1:0].
- Store data: byte is replicated 4x, half 2x, word passed through.
- REQ: o_dmem_req=1 and held stable until i_dmem_gnt.
  - Write + gnt: go to DONE.
  - Read + gnt + rvalid in the same cycle (zero-wait memory): capture data, go to DONE.
  - Read + gnt without rvalid: go to WAIT_R.
  - o_dmem_req drops in the cycle after gnt.
- WAIT_R: o_dmem_req=0. On i_dmem_rvalid, capture data and go to DONE.
- DONE: o_done=1, o_stall=0, o_rdata is valid. Return to IDLE next cycle.
  - o_rdata holds its value until the next load completes.
- Load align: rdata >> (8*addr[1:0]), then mask to size. Sign-extend from bit 7 (byte) or bit 15 (half) unless unsigned.
- o_stall = start-this-cycle || state is REQ or WAIT_R.
- Ignored inputs:
  - i_dmem_rvalid outside REQ/WAIT_R is ignored.
  - i_dmem_gnt while o_dmem_req=0 is ignored.
- Reset asserted mid-access: return to IDLE immediately and drop req. An outstanding rvalid arriving after reset is ignored.
- Latency with zero-wait memory:
  - Start cycle: stall.
  - REQ: stall.
  - DONE: o_done.
  - Result is available 2 cycles after start.
- No timeout. The memory must eventually grant and return data.

Decomposition:
- Package lsu_pkg holds:
  - Size-mask constants: SIZE_B=4'b0001, SIZE_H=4'b0011, SIZE_W=4'b1111.
  - FSM state enum lsu_state_e.
  - Function is_misaligned(size, addr[1:0]).
- One combinational sub-module, lsu_load_align (rdata, offset, size, unsigned → result), instantiated once and unit-testable on its own.
- Store-lane replication and byte-enable shifting stay inline in lsu_dmem_ctrl.

Test Plan:
- Word store: addr=0x1004, wdata=0xDEADBEEF, gnt on the first REQ cycle → be=1111, addr=0x1004, wdata=0xDEADBEEF, o_done 2 cycles after start.
- Byte store: addr=0x2003, wdata=0x000000A5 → be=1000, wdata=0xA5A5A5A5.
- Signed byte load: addr=0x10, rdata=0x80FF7F01, gnt+rvalid same cycle → o_rdata=0x00000001.
  - Same test at addr=0x12 → 0xFFFFFFFF.
  - Same test with unsigned at addr=0x13 → 0x00000080.
- Half load with memory latency: addr=0x22, gnt delayed 3 cycles, rvalid 2 cycles later, rdata=0x8001_1234 → req held for 4 cycles, stall held throughout, o_rdata=0xFFFF8001.
- Faults: half at addr=0x31 → o_fault pulse, no req, no stall. Size 0111 → o_fault. Word at 0x32 → o_fault.
- Reset in WAIT_R: assert i_rst_n=0, then drive rvalid after release → state IDLE, o_done stays 0, o_rdata stays 0.
